// File: rtl/trigger_pulse_gen_pkg.sv
// Shared definitions for the trigger pulse generator and the benches that drive
// the trigger-qualifying FSM: command codes, state encoding, default timing.
package trigger_pulse_gen_pkg;

  // Command codes carried on cmd_code
  localparam logic [1:0] CMD_NOP    = 2'b00;
  localparam logic [1:0] CMD_SHORT  = 2'b01;
  localparam logic [1:0] CMD_LONG   = 2'b10;
  localparam logic [1:0] CMD_DOUBLE = 2'b11;

  // Generator state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PULSE = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Default timing, also used by benches of the downstream FSM
  localparam int unsigned DEF_SHORT_CYC = 2;
  localparam int unsigned DEF_LONG_CYC  = 30;
  localparam int unsigned DEF_GAP_CYC   = 15;
  localparam int unsigned DEF_CNT_W     = 8;

  // True when a cycle count can be loaded into a w-bit down-counter
  // and still reach the terminal value of 1.
  function automatic bit cyc_legal(input int unsigned v, input int unsigned w);
    return (v >= 1) && (64'(v) < (64'd1 << w));
  endfunction

endpackage

// File: rtl/trigger_pulse_gen_if.sv
// Command handshake plus generated waveform/status of the trigger pulse generator.
interface trigger_pulse_gen_if;

  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic       cmd_ready;
  logic       trigger;
  logic       busy;
  logic       done;

  // Side issuing commands and observing the waveform
  modport master (
    output cmd_valid,
    output cmd_code,
    input  cmd_ready,
    input  trigger,
    input  busy,
    input  done
  );

  // The generator itself
  modport slave (
    input  cmd_valid,
    input  cmd_code,
    output cmd_ready,
    output trigger,
    output busy,
    output done
  );

endinterface

// File: rtl/trigger_pulse_gen_cycle_timer.sv
// Loadable down-counter used to time both the high and the low phases.
// 'last' flags the final cycle of a phase (count == 1).
module cycle_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             enable,
  output logic             last
);

  logic [CNT_W-1:0] count_reg;

  // Load has priority; an idle counter parked at zero never wraps
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (enable && (count_reg != '0)) begin
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  assign last = (count_reg == CNT_W'(1));

endmodule

// File: rtl/trigger_pulse_gen.sv
// Turns a one-cycle command handshake into a timed trigger waveform:
// short pulse, long hold or double short pulse, each followed by a low gap.
// All outputs are registered copies of the state decode, so the externally
// visible waveform trails the state register by one clock and nothing on
// cmd_* reaches trigger combinationally.
module trigger_pulse_gen
  import trigger_pulse_gen_pkg::*;
#(
  parameter int unsigned SHORT_CYC = DEF_SHORT_CYC,
  parameter int unsigned LONG_CYC  = DEF_LONG_CYC,
  parameter int unsigned GAP_CYC   = DEF_GAP_CYC,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input  logic                m_clk,
  input  logic                m_reset,
  trigger_pulse_gen_if.slave  bus
);

  // Reject phase lengths the counter cannot represent
  generate
    if (!cyc_legal(SHORT_CYC, CNT_W) || !cyc_legal(LONG_CYC, CNT_W) ||
        !cyc_legal(GAP_CYC, CNT_W)) begin : g_bad_param
      $error("trigger_pulse_gen: SHORT_CYC/LONG_CYC/GAP_CYC must be in 1..2**CNT_W-1");
    end
  endgenerate

  localparam logic [CNT_W-1:0] SHORT_LD = CNT_W'(SHORT_CYC);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC);

  state_t           state_reg, state_next;
  logic             dbl_reg, dbl_next;
  logic             ready_reg, busy_reg, trigger_reg, done_reg;
  logic             accept;
  logic             idle_next_ready;
  logic             tmr_load, tmr_enable, tmr_last;
  logic [CNT_W-1:0] tmr_load_val;

  // ready_reg is only ever high while the state register holds IDLE
  assign accept          = bus.cmd_valid & ready_reg;
  assign idle_next_ready = (state_reg == ST_IDLE) && !accept;

  cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (m_clk),
    .rst      (m_reset),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .enable   (tmr_enable),
    .last     (tmr_last)
  );

  // State and double-pulse flag registers
  always_ff @(posedge m_clk or posedge m_reset) begin
    if (m_reset) begin
      state_reg <= ST_IDLE;
      dbl_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      dbl_reg   <= dbl_next;
    end
  end

  // Next-state and timer control
  always_comb begin
    state_next   = state_reg;
    dbl_next     = dbl_reg;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_enable   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          case (bus.cmd_code)
            CMD_SHORT: begin
              tmr_load     = 1'b1;
              tmr_load_val = SHORT_LD;
              state_next   = ST_PULSE;
            end
            CMD_LONG: begin
              tmr_load     = 1'b1;
              tmr_load_val = LONG_LD;
              state_next   = ST_PULSE;
            end
            CMD_DOUBLE: begin
              tmr_load     = 1'b1;
              tmr_load_val = SHORT_LD;
              dbl_next     = 1'b1;
              state_next   = ST_PULSE;
            end
            default: begin
              state_next = ST_DONE;
            end
          endcase
        end
      end
      ST_PULSE: begin
        tmr_enable = 1'b1;
        if (tmr_last) begin
          tmr_load     = 1'b1;
          tmr_load_val = GAP_LD;
          state_next   = ST_GAP;
        end
      end
      ST_GAP: begin
        tmr_enable = 1'b1;
        if (tmr_last) begin
          if (dbl_reg) begin
            dbl_next     = 1'b0;
            tmr_load     = 1'b1;
            tmr_load_val = SHORT_LD;
            state_next   = ST_PULSE;
          end else begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Registered outputs; accept clears ready at the accepting edge so a
  // single command can never be taken twice
  always_ff @(posedge m_clk or posedge m_reset) begin
    if (m_reset) begin
      ready_reg   <= 1'b1;
      busy_reg    <= 1'b0;
      trigger_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      ready_reg   <= idle_next_ready;
      busy_reg    <= !idle_next_ready;
      trigger_reg <= (state_reg == ST_PULSE);
      done_reg    <= (state_reg == ST_DONE);
    end
  end

  assign bus.cmd_ready = ready_reg;
  assign bus.busy      = busy_reg;
  assign bus.trigger   = trigger_reg;
  assign bus.done      = done_reg;

endmodule

// File: tb/tb_trigger_pulse_gen.sv
// Directed bench for trigger_pulse_gen: per-cycle waveform checks against
// hand-derived edge timing for every command type, reset behaviour,
// busy-ignore of a held command and asynchronous reset mid-pulse.
module tb_trigger_pulse_gen;

  localparam int SHORT = 2;
  localparam int LONG  = 30;
  localparam int GAP   = 15;

  logic m_clk   = 1'b0;
  logic m_reset = 1'b1;
  int   n_vec   = 0;
  int   n_miss  = 0;

  trigger_pulse_gen_if bus ();

  trigger_pulse_gen #(
    .SHORT_CYC (SHORT),
    .LONG_CYC  (LONG),
    .GAP_CYC   (GAP),
    .CNT_W     (8)
  ) dut (
    .m_clk   (m_clk),
    .m_reset (m_reset),
    .bus     (bus)
  );

  always #5 m_clk = ~m_clk;

  // One comparison: count it, report a mismatch
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1 ns later
  task automatic step();
    @(posedge m_clk);
    #1;
  endtask

  // Present a command for one edge while idle, then check the accept cycle
  task automatic accept_cmd(input logic [1:0] code);
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = code;
    step();
    bus.cmd_valid = 1'b0;
    chk("acc_busy", 32'(bus.busy), 32'd1);
    chk("acc_ready", 32'(bus.cmd_ready), 32'd0);
    chk("acc_trig", 32'(bus.trigger), 32'd0);
  endtask

  // Check every cycle after accept at edge k up to cmd_ready returning.
  // Post-edge k+i: trigger high for i in 1..N (and the second pulse for
  // double), done at i = total+1, ready at i = total+2.
  task automatic check_seq(input logic [1:0] code, input string name);
    int n;
    int total;
    logic e_trig, e_done, e_rdy;
    case (code)
      2'b01:   begin n = SHORT; total = SHORT + GAP; end
      2'b10:   begin n = LONG;  total = LONG + GAP; end
      2'b11:   begin n = SHORT; total = 2 * (SHORT + GAP); end
      default: begin n = 0;     total = 0; end
    endcase
    for (int i = 1; i <= total + 2; i++) begin
      step();
      e_trig = ((i >= 1) && (i <= n)) ||
               ((code == 2'b11) && (i >= n + GAP + 1) && (i <= 2 * n + GAP));
      e_done = (i == total + 1);
      e_rdy  = (i == total + 2);
      chk($sformatf("%s_trig@%0d", name, i), 32'(bus.trigger), 32'(e_trig));
      chk($sformatf("%s_done@%0d", name, i), 32'(bus.done), 32'(e_done));
      chk($sformatf("%s_ready@%0d", name, i), 32'(bus.cmd_ready), 32'(e_rdy));
      chk($sformatf("%s_busy@%0d", name, i), 32'(bus.busy), 32'(!e_rdy));
    end
  endtask

  logic trig_hist [1:70];

  initial begin
    int acc2;
    int rise;
    int hi1;
    int hi2;
    logic prev_rdy;

    // Reset held 10 cycles with a long command pending
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = 2'b10;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_trig", 32'(bus.trigger), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
      chk("rst_done", 32'(bus.done), 32'd0);
    end
    m_reset = 1'b0;
    // First edge after release accepts the pending long command
    step();
    bus.cmd_valid = 1'b0;
    chk("rel_busy", 32'(bus.busy), 32'd1);
    chk("rel_ready", 32'(bus.cmd_ready), 32'd0);
    check_seq(2'b10, "long");

    // Short pulse
    accept_cmd(2'b01);
    check_seq(2'b01, "short");

    // Double short pulse
    accept_cmd(2'b11);
    check_seq(2'b11, "double");

    // Nop
    accept_cmd(2'b00);
    check_seq(2'b00, "nop");

    // Short command with a long command held valid throughout
    bus.cmd_valid = 1'b1;
    bus.cmd_code  = 2'b01;
    step();
    bus.cmd_code = 2'b10;
    prev_rdy = 1'b0;
    acc2 = 0;
    for (int j = 1; j <= 70; j++) begin
      step();
      trig_hist[j] = bus.trigger;
      if (prev_rdy && !bus.cmd_ready && (acc2 == 0)) begin
        acc2 = j;
        bus.cmd_valid = 1'b0;
      end
      prev_rdy = bus.cmd_ready;
    end
    hi1 = 0;
    hi2 = 0;
    rise = 0;
    for (int j = 1; j <= 19; j++) if (trig_hist[j]) hi1++;
    for (int j = 3; j <= 70; j++) if (trig_hist[j] && (rise == 0)) rise = j;
    for (int j = 20; j <= 70; j++) if (trig_hist[j]) hi2++;
    chk("held_acc_edge", 32'(acc2), 32'd20);
    chk("held_hi1", 32'(hi1), 32'(SHORT));
    chk("held_gap_min", 32'((rise - 3) >= GAP + 2), 32'd1);
    chk("held_hi2", 32'(hi2), 32'(LONG));
    chk("held_idle", 32'(bus.cmd_ready), 32'd1);

    // Asynchronous reset at cycle 10 of a long hold
    accept_cmd(2'b10);
    for (int i = 1; i <= 10; i++) step();
    chk("mid_trig_hi", 32'(bus.trigger), 32'd1);
    #2;
    m_reset = 1'b1;
    #1;
    chk("mid_trig_async", 32'(bus.trigger), 32'd0);
    chk("mid_busy_async", 32'(bus.busy), 32'd0);
    chk("mid_ready_async", 32'(bus.cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_done", 32'(bus.done), 32'd0);
    end
    m_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_trig", 32'(bus.trigger), 32'd0);
      chk("post_done", 32'(bus.done), 32'd0);
      chk("post_ready", 32'(bus.cmd_ready), 32'd1);
      chk("post_busy", 32'(bus.busy), 32'd0);
    end

    // Generator still works after the lost command
    accept_cmd(2'b01);
    check_seq(2'b01, "short2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
